// File: rtl/ntt_pkg.sv
// Shared codes for the NTT/PWM/INTT control path: conf encodings, host op codes,
// done_flag bit positions, response status codes and the sequencer state type.
package ntt_pkg;

  localparam logic [2:0] CONF_IDLE      = 3'b000;
  localparam logic [2:0] CONF_NTT       = 3'b001;
  localparam logic [2:0] CONF_PWM       = 3'b010;
  localparam logic [2:0] CONF_INTT      = 3'b011;
  localparam logic [2:0] CONF_DONE_NTT  = 3'b100;
  localparam logic [2:0] CONF_DONE_INTT = 3'b101;

  localparam logic [1:0] OP_NTT  = 2'b00;
  localparam logic [1:0] OP_PWM  = 2'b01;
  localparam logic [1:0] OP_INTT = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  localparam int DONE_BIT_NTT  = 0;
  localparam int DONE_BIT_PWM  = 1;
  localparam int DONE_BIT_INTT = 2;

  localparam logic [1:0] STATUS_OK      = 2'b00;
  localparam logic [1:0] STATUS_ILLEGAL = 2'b01;
  localparam logic [1:0] STATUS_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10,
    ST_RESP  = 2'b11
  } seq_state_t;

  function automatic logic [2:0] op_conf(input logic [1:0] op);
    logic [2:0] c;
    case (op)
      OP_NTT:  c = CONF_NTT;
      OP_PWM:  c = CONF_PWM;
      OP_INTT: c = CONF_INTT;
      default: c = CONF_IDLE;
    endcase
    return c;
  endfunction

  // PWM shares the NTT drain code: only the inverse transform has its own tail.
  function automatic logic [2:0] op_drain_conf(input logic [1:0] op);
    logic [2:0] c;
    case (op)
      OP_INTT: c = CONF_DONE_INTT;
      default: c = CONF_DONE_NTT;
    endcase
    return c;
  endfunction

  function automatic logic [3:0] op_done_mask(input logic [1:0] op);
    logic [3:0] m;
    m = 4'b0000;
    case (op)
      OP_NTT:  m[DONE_BIT_NTT]  = 1'b1;
      OP_PWM:  m[DONE_BIT_PWM]  = 1'b1;
      OP_INTT: m[DONE_BIT_INTT] = 1'b1;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ntt_cmd_seq_down_cnt.sv
// Loadable 4-bit down-counter with a zero flag; holds at zero, load has priority.
module seq_down_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] cnt_r;

  // Counter register: load wins over decrement, never wraps below zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= 4'd0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != 4'd0)) begin
      cnt_r <= cnt_r - 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == 4'd0);

endmodule

// File: rtl/ntt_cmd_seq.sv
// Host command sequencer for the NTT/PWM/INTT index FSM: issues conf, waits for the
// matching done bit (or timeout), holds the drain code, then returns a response.
module ntt_cmd_seq
  import ntt_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES   = 10,
  parameter int unsigned TIMEOUT_CYCLES = 2047
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  output logic [2:0]  conf,
  input  logic [3:0]  done_flag,
  output logic        busy,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [1:0]  resp_status,
  output logic [11:0] resp_cycles
);

  localparam logic [3:0]  DRAIN_LOAD   = 4'(DRAIN_CYCLES - 1);
  localparam logic [12:0] TIMEOUT_VAL  = 13'(TIMEOUT_CYCLES);
  localparam logic [11:0] TIMEOUT_RESP = 12'(TIMEOUT_CYCLES);

  seq_state_t  state_r;
  logic [1:0]  op_r;
  logic [11:0] run_cnt_r;
  logic [12:0] run_next_s;
  logic [11:0] run_sat_s;
  logic        done_hit_s;
  logic        timeout_s;
  logic        drain_load_s;
  logic        drain_dec_s;
  logic        drain_zero_s;

  // run_cnt+1 is kept 13 bits wide so the timeout compare cannot alias on wrap.
  assign run_next_s = {1'b0, run_cnt_r} + 13'd1;
  assign run_sat_s  = (run_cnt_r == 12'hFFF) ? run_cnt_r : run_next_s[11:0];

  // RUN exit conditions and drain-counter control.
  always_comb begin
    done_hit_s   = 1'b0;
    timeout_s    = 1'b0;
    drain_load_s = 1'b0;
    drain_dec_s  = 1'b0;
    case (state_r)
      ST_RUN: begin
        done_hit_s   = |(done_flag & op_done_mask(op_r));
        timeout_s    = (run_next_s == TIMEOUT_VAL);
        drain_load_s = done_hit_s | timeout_s;
      end
      ST_DRAIN: begin
        drain_dec_s = ~drain_zero_s;
      end
      default: begin
        drain_dec_s = 1'b0;
      end
    endcase
  end

  seq_down_cnt u_drain_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (drain_load_s),
    .load_val (DRAIN_LOAD),
    .dec      (drain_dec_s),
    .zero     (drain_zero_s)
  );

  // Sequencer FSM with all host- and FSM-facing outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      op_r        <= OP_NTT;
      run_cnt_r   <= 12'd0;
      conf        <= CONF_IDLE;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      resp_valid  <= 1'b0;
      resp_status <= STATUS_OK;
      resp_cycles <= 12'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            op_r      <= cmd_op;
            if (cmd_op == OP_RSVD) begin
              state_r     <= ST_RESP;
              resp_valid  <= 1'b1;
              resp_status <= STATUS_ILLEGAL;
              resp_cycles <= 12'd0;
            end else begin
              state_r   <= ST_RUN;
              conf      <= op_conf(cmd_op);
              busy      <= 1'b1;
              run_cnt_r <= 12'd0;
            end
          end
        end
        ST_RUN: begin
          run_cnt_r <= run_sat_s;
          // A done in the timeout cycle still counts as success.
          if (done_hit_s) begin
            state_r     <= ST_DRAIN;
            conf        <= op_drain_conf(op_r);
            resp_status <= STATUS_OK;
            resp_cycles <= run_sat_s;
          end else if (timeout_s) begin
            state_r     <= ST_DRAIN;
            conf        <= op_drain_conf(op_r);
            resp_status <= STATUS_TIMEOUT;
            resp_cycles <= TIMEOUT_RESP;
          end
        end
        ST_DRAIN: begin
          if (drain_zero_s) begin
            state_r    <= ST_RESP;
            conf       <= CONF_IDLE;
            busy       <= 1'b0;
            resp_valid <= 1'b1;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            state_r    <= ST_IDLE;
            resp_valid <= 1'b0;
            cmd_ready  <= 1'b1;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          conf       <= CONF_IDLE;
          cmd_ready  <= 1'b1;
          busy       <= 1'b0;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
